// File: rtl/set_dispatch.sv
// Job dispatcher for the SET unit: queues tagged jobs, issues them one at a time and
// returns each result, or a timeout error, on a valid/ready result port.
module set_dispatch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_central,
    input  logic [11:0] job_radius,
    input  logic [1:0]  job_mode,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic [5:0]  res_tag,
    output logic        res_err,
    output logic        idle
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
        logic [5:0]  tag;
    } job_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e state_q, state_d;

    job_t          mem [FIFO_DEPTH];
    job_t          head;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [5:0]    tag_q;
    logic [5:0]    cur_tag_q;
    logic [CW-1:0] wait_cnt_q;

    logic empty, full, push, pop, issue_start, wait_done;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign job_ready   = !full;
    assign push        = job_valid && job_ready;
    assign pop         = (state_q == StIssue);
    assign head        = mem[rd_ptr_q[AW-1:0]];
    assign wait_done   = (wait_cnt_q == WAIT_LAST);
    assign issue_start = (state_q == StIdle) && (state_d == StIssue);
    assign idle        = empty && (state_q == StIdle) && !res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty && !set_busy && !res_valid) begin
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (set_valid || wait_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        set_en = (state_q == StIssue);
    end

    // Queue storage needs no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= '{job_central, job_radius, job_mode, tag_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_q         <= '0;
            cur_tag_q     <= '0;
            wait_cnt_q    <= '0;
            set_central   <= '0;
            set_radius    <= '0;
            set_mode      <= '0;
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_err       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                tag_q    <= tag_q + 6'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            // Operands are captured one edge early so they are valid alongside set_en.
            if (issue_start) begin
                set_central <= head.central;
                set_radius  <= head.radius;
                set_mode    <= head.mode;
                cur_tag_q   <= head.tag;
            end
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (state_q == StWait) begin
                if (set_valid) begin
                    res_valid     <= 1'b1;
                    res_candidate <= set_candidate;
                    res_tag       <= cur_tag_q;
                    res_err       <= 1'b0;
                    wait_cnt_q    <= '0;
                end else if (wait_done) begin
                    res_valid     <= 1'b1;
                    res_candidate <= '0;
                    res_tag       <= cur_tag_q;
                    res_err       <= 1'b1;
                    wait_cnt_q    <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_set_dispatch.sv
// Directed testbench for set_dispatch with a small SET responder and a result log.
module tb_set_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, job_valid, job_ready;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy, set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid, res_ready;
    logic [7:0]  res_candidate;
    logic [5:0]  res_tag;
    logic        res_err, idle;

    logic       set_valid_man;
    logic [7:0] cand_man;
    logic       model_auto;
    int         model_lat;
    int         model_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [56:0] RST_VEC = {1'b1, 55'd0, 1'b1};
    logic [56:0] obs;

    // SET responder: answers model_lat cycles after set_en, echoing the low operand byte.
    assign set_valid     = set_valid_man | (model_auto && model_cnt == 1);
    assign set_candidate = model_auto ? set_central[7:0] : cand_man;

    always @(posedge clk) begin
        if (!model_auto) model_cnt <= 0;
        else if (set_en) model_cnt <= model_lat;
        else if (model_cnt > 0) model_cnt <= model_cnt - 1;
    end

    int         en_pulses = 0;
    int         log_n     = 0;
    logic [5:0] log_tag  [256];
    logic [7:0] log_cand [256];
    logic       log_err  [256];

    always @(posedge clk) begin
        if (set_en) en_pulses <= en_pulses + 1;
        if (res_valid && res_ready && log_n < 256) begin
            log_tag[log_n]  <= res_tag;
            log_cand[log_n] <= res_candidate;
            log_err[log_n]  <= res_err;
            log_n           <= log_n + 1;
        end
    end

    set_dispatch #(
        .FIFO_DEPTH(4),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_central  (job_central),
        .job_radius   (job_radius),
        .job_mode     (job_mode),
        .set_en       (set_en),
        .set_central  (set_central),
        .set_radius   (set_radius),
        .set_mode     (set_mode),
        .set_busy     (set_busy),
        .set_valid    (set_valid),
        .set_candidate(set_candidate),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_candidate(res_candidate),
        .res_tag      (res_tag),
        .res_err      (res_err),
        .idle         (idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; job_valid = 1'b0; set_busy = 1'b0; set_valid_man = 1'b0;
        model_auto = 1'b0; res_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        obs = {job_ready, set_en, set_central, set_radius, set_mode, res_valid,
               res_candidate, res_tag, res_err, idle};
        n_checks++;
        if (obs !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", obs, RST_VEC);
        end
        // Stray strobe while idle must be ignored.
        set_valid_man = 1'b1; cand_man = 8'hAA;
        tick();
        set_valid_man = 1'b0;
        tick();
        n_checks++;
        if ({res_valid, idle, set_en} !== 3'b010) begin
            n_fail++;
            $display("FAIL stray_idle: got {valid,idle,en}=%b required 010",
                     {res_valid, idle, set_en});
        end
    endtask

    task automatic test_single_job();
        int p0;
        do_reset();
        p0 = en_pulses;
        job_valid = 1'b1; job_central = 24'h123456; job_radius = 12'h321; job_mode = 2'b01;
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_fail++; $display("FAIL sj_ready: got %b required 1", job_ready);
        end
        tick();
        job_valid = 1'b0; job_central = 24'hFFFFFF; job_radius = 12'hFFF; job_mode = 2'b11;
        n_checks++;
        if (set_en !== 1'b0) begin
            n_fail++; $display("FAIL sj_en_early: got %b required 0", set_en);
        end
        tick();
        n_checks++;
        if ({set_en, set_central, set_radius, set_mode} !== {1'b1, 24'h123456, 12'h321, 2'b01})
        begin
            n_fail++;
            $display("FAIL sj_issue: got en=%b c=%h r=%h m=%b required en=1 c=123456 r=321 m=01",
                     set_en, set_central, set_radius, set_mode);
        end
        set_busy = 1'b1;
        tick();
        n_checks++;
        if (set_en !== 1'b0) begin
            n_fail++; $display("FAIL sj_en_pulse: got %b required 0", set_en);
        end
        repeat (9) tick();
        n_checks++;
        if ({res_valid, set_central, set_radius, set_mode} !==
            {1'b0, 24'h123456, 12'h321, 2'b01}) begin
            n_fail++;
            $display("FAIL sj_wait_hold: got v=%b c=%h r=%h m=%b", res_valid, set_central,
                     set_radius, set_mode);
        end
        set_busy = 1'b0; set_valid_man = 1'b1; cand_man = 8'd17;
        tick();
        set_valid_man = 1'b0;
        n_checks++;
        if ({res_valid, res_candidate, res_tag, res_err} !== {1'b1, 8'd17, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL sj_result: got v=%b c=%0d t=%0d e=%b required v=1 c=17 t=0 e=0",
                     res_valid, res_candidate, res_tag, res_err);
        end
        n_checks++;
        if (en_pulses - p0 !== 1) begin
            n_fail++; $display("FAIL sj_pulses: got %0d required 1", en_pulses - p0);
        end
        tick();
        n_checks++;
        if ({res_valid, res_candidate, idle} !== {1'b1, 8'd17, 1'b0}) begin
            n_fail++;
            $display("FAIL sj_res_hold: got v=%b c=%0d idle=%b", res_valid, res_candidate, idle);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, idle} !== 2'b01) begin
            n_fail++; $display("FAIL sj_clear: got {v,idle}=%b required 01", {res_valid, idle});
        end
    endtask

    task automatic test_queue_full();
        int n, base;
        do_reset();
        set_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            job_valid = 1'b1; job_central = {16'hC0DE, 8'(i + 1)}; job_radius = 12'h0;
            job_mode = 2'b10;
            n_checks++;
            if (job_ready !== 1'b1) begin
                n_fail++; $display("FAIL qf_ready_%0d: got %b required 1", i, job_ready);
            end
            tick();
        end
        job_central = {16'hC0DE, 8'd5};
        n_checks++;
        if (job_ready !== 1'b0) begin
            n_fail++; $display("FAIL qf_full: got %b required 0", job_ready);
        end
        tick(); tick();
        n_checks++;
        if ({job_ready, set_en} !== 2'b00) begin
            n_fail++; $display("FAIL qf_busy_hold: got {ready,en}=%b required 00",
                               {job_ready, set_en});
        end
        model_auto = 1'b1; model_lat = 2; res_ready = 1'b1; base = log_n;
        set_busy = 1'b0;
        tick();
        n_checks++;
        if ({set_en, job_ready, set_central} !== {1'b1, 1'b0, 24'hC0DE01}) begin
            n_fail++;
            $display("FAIL qf_issue: got en=%b ready=%b c=%h required en=1 ready=0 c=c0de01",
                     set_en, job_ready, set_central);
        end
        tick();
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_fail++; $display("FAIL qf_ready_after_pop: got %b required 1", job_ready);
        end
        tick();
        job_valid = 1'b0;
        n_checks++;
        if (job_ready !== 1'b0) begin
            n_fail++; $display("FAIL qf_refull: got %b required 0", job_ready);
        end
        n = 0;
        while (log_n - base < 5 && n < 300) begin tick(); n++; end
        n_checks++;
        if (log_n - base !== 5) begin
            n_fail++; $display("FAIL qf_count: got %0d results required 5", log_n - base);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({log_tag[base+i], log_cand[base+i], log_err[base+i]} !==
                {6'(i), 8'(i + 1), 1'b0}) begin
                n_fail++;
                $display("FAIL qf_res_%0d: got t=%0d c=%0d e=%b required t=%0d c=%0d e=0", i,
                         log_tag[base+i], log_cand[base+i], log_err[base+i], i, i + 1);
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n, p0;
        do_reset();
        model_auto = 1'b1; model_lat = 3;
        job_valid = 1'b1; job_central = {16'hBEEF, 8'h11}; tick();
        job_central = {16'hBEEF, 8'h22}; tick();
        job_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        n_checks++;
        if ({res_valid, res_tag, res_candidate} !== {1'b1, 6'd0, 8'h11}) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b t=%0d c=%h required v=1 t=0 c=11", res_valid,
                     res_tag, res_candidate);
        end
        p0 = en_pulses;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if ({res_valid, set_en, res_tag, res_candidate} !== {1'b1, 1'b0, 6'd0, 8'h11}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got v=%b en=%b t=%0d c=%h", i, res_valid, set_en,
                         res_tag, res_candidate);
            end
        end
        n_checks++;
        if (en_pulses !== p0) begin
            n_fail++; $display("FAIL bp_no_issue: got %0d pulses required 0", en_pulses - p0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, set_en} !== 2'b00) begin
            n_fail++; $display("FAIL bp_clear: got {v,en}=%b required 00", {res_valid, set_en});
        end
        tick();
        n_checks++;
        if ({set_en, set_central} !== {1'b1, 24'hBEEF22}) begin
            n_fail++;
            $display("FAIL bp_second_issue: got en=%b c=%h required en=1 c=beef22", set_en,
                     set_central);
        end
        n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        n_checks++;
        if ({res_valid, res_tag, res_candidate, res_err} !== {1'b1, 6'd1, 8'h22, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b t=%0d c=%h e=%b required v=1 t=1 c=22 e=0",
                     res_valid, res_tag, res_candidate, res_err);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        job_valid = 1'b1; job_central = {16'h0, 8'h31}; tick();
        job_central = {16'h0, 8'h32}; tick();
        job_valid = 1'b0;
        n_checks++;
        if (set_en !== 1'b1) begin
            n_fail++; $display("FAIL to_issue: got %b required 1", set_en);
        end
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++; $display("FAIL to_early_%0d: got %b required 0", i, res_valid);
            end
        end
        tick();
        n_checks++;
        if ({res_valid, res_err, res_candidate, res_tag} !== {1'b1, 1'b1, 8'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL to_result: got v=%b e=%b c=%0d t=%0d required v=1 e=1 c=0 t=0",
                     res_valid, res_err, res_candidate, res_tag);
        end
        // Second job answers exactly on the timeout cycle; the valid result must win.
        model_auto = 1'b1; model_lat = 16;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        tick();
        n_checks++;
        if ({set_en, set_central[7:0]} !== {1'b1, 8'h32}) begin
            n_fail++;
            $display("FAIL to_next_issue: got en=%b c=%h required en=1 c=32", set_en,
                     set_central[7:0]);
        end
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++; $display("FAIL tie_early_%0d: got %b required 0", i, res_valid);
            end
        end
        tick();
        n_checks++;
        if ({res_valid, res_err, res_candidate, res_tag} !== {1'b1, 1'b0, 8'h32, 6'd1}) begin
            n_fail++;
            $display("FAIL tie_result: got v=%b e=%b c=%h t=%0d required v=1 e=0 c=32 t=1",
                     res_valid, res_err, res_candidate, res_tag);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        model_auto = 1'b0;
    endtask

    task automatic test_tag_wrap();
        int n, base, sent;
        logic acc;
        do_reset();
        model_auto = 1'b1; model_lat = 1; res_ready = 1'b1; base = log_n; sent = 0; n = 0;
        while (sent < 65 && n < 2000) begin
            job_valid = 1'b1; job_central = {16'h07A6, 8'(sent)};
            acc = job_ready;
            tick(); n++;
            if (acc) sent++;
        end
        job_valid = 1'b0;
        n_checks++;
        if (sent !== 65) begin
            n_fail++; $display("FAIL tw_sent: got %0d required 65", sent);
        end
        n = 0;
        while (log_n - base < 65 && n < 1000) begin tick(); n++; end
        repeat (10) tick();
        n_checks++;
        if (log_n - base !== 65) begin
            n_fail++; $display("FAIL tw_count: got %0d results required 65", log_n - base);
        end
        for (int i = 0; i < 65; i++) begin
            n_checks++;
            if ({log_tag[base+i], log_cand[base+i], log_err[base+i]} !==
                {6'(i), 8'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL tw_res_%0d: got t=%0d c=%0d e=%b required t=%0d c=%0d e=0", i,
                         log_tag[base+i], log_cand[base+i], log_err[base+i], i % 64, i);
            end
        end
        res_ready = 1'b0; model_auto = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        job_valid = 1'b1; job_central = {16'h0, 8'h41}; tick();
        job_central = {16'h0, 8'h42}; tick();
        job_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        set_valid_man = 1'b1; cand_man = 8'd9;
        tick();
        set_valid_man = 1'b0;
        for (int i = 0; i < 6; i++) begin
            obs = {job_ready, set_en, set_central, set_radius, set_mode, res_valid,
                   res_candidate, res_tag, res_err, idle};
            n_checks++;
            if (obs !== RST_VEC) begin
                n_fail++;
                $display("FAIL rmw_outputs_%0d: got %h required %h", i, obs, RST_VEC);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_central = '0; job_radius = '0; job_mode = '0;
        set_busy = 1'b0; set_valid_man = 1'b0; cand_man = '0; model_auto = 1'b0;
        model_lat = 1; res_ready = 1'b0;
        tick();
        test_reset();
        test_single_job();
        test_queue_full();
        test_backpressure();
        test_timeout();
        test_tag_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

endmodule

// File: doc/set_dispatch.md
SET_DISPATCH -- requirements
Module: set_dispatch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, job queue depth (power of two, at least 2).
REQ-002 Parameter TIMEOUT, default 1023, maximum number of cycles spent in WAIT before the job is aborted.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 job_valid  in  1  upstream job offered.
REQ-006 job_ready  out  1  job queue can accept a job.
REQ-007 job_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each.
REQ-008 job_radius  in  12  {r1,r2,r3}, 4 bits each.
REQ-009 job_mode  in  2  set operation code passed through to SET.
REQ-010 set_en  out  1  one-cycle start strobe to SET.
REQ-011 set_central  out  24; set_radius  out  12; set_mode  out  2  operands to SET.
REQ-012 set_busy  in  1  SET busy flag.
REQ-013 set_valid  in  1  SET result strobe.
REQ-014 set_candidate  in  8  SET result count.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  downstream accepts the result.
REQ-017 res_candidate  out  8  result count.
REQ-018 res_tag  out  6  job sequence tag.
REQ-019 res_err  out  1  the job timed out.
REQ-020 idle  out  1  queue empty, FSM in IDLE, and no result pending.

Function
REQ-021 Job acceptance: a job is accepted on any edge where job_valid=1 and job_ready=1; job_ready=!full (no same-cycle bypass when full, even if a pop occurs).
REQ-022 Tagging: each accepted job is stored with its tag, taken from a 6-bit counter that increments per acceptance and wraps 63->0.
REQ-023 FSM states: IDLE, ISSUE, WAIT.
REQ-024 IDLE->ISSUE transition: the queue is non-empty, set_busy=0, and res_valid=0.
REQ-025 ISSUE: set_en=1 for exactly one cycle; set_central/set_radius/set_mode are loaded from the queue head; the entry is popped; the FSM goes to WAIT.
REQ-026 Operand hold: set_central/set_radius/set_mode are registered and remain stable from ISSUE until the next ISSUE.
REQ-027 WAIT, normal completion: when set_valid=1, res_candidate<=set_candidate, res_tag<=the job's tag, res_err<=0, res_valid<=1, and the FSM goes to IDLE.
REQ-028 WAIT, timeout: the wait counter counts cycles in WAIT; on reaching TIMEOUT without set_valid, res_candidate<=0, res_err<=1, res_valid<=1, and the FSM goes to IDLE.
REQ-029 Timeout/valid tie: if set_valid arrives on the timeout cycle, the valid result wins and res_err=0.
REQ-030 Result hold: res_valid stays 1 with res_* stable until an edge where res_ready=1; it then clears. No new job issues while res_valid=1.
REQ-031 Stray strobes: set_valid outside WAIT is ignored, with no state change.
REQ-032 Minimum latency: a job accepted at edge k into an empty queue with SET idle gives set_en high between edges k+1 and k+2. res_valid rises at the same edge where set_valid is sampled high.
REQ-033 Empty queue: the FSM stays in IDLE and set_en=0.

Reset
REQ-034 rst=1 at an edge clears the queue (empty, job_ready=1), tag counter=0, wait counter=0, FSM=IDLE, set_en=0, set_central=0, set_radius=0, set_mode=0, res_valid=0, res_candidate=0, res_tag=0, res_err=0, idle=1.
REQ-035 Reset in any state, including WAIT, discards in-flight and queued jobs; set_valid arriving after reset is ignored per REQ-031.

Verification
REQ-036 Single job: central=24'h123456, radius=12'h321, mode=2'b01; bench SET model busy for 10 cycles, then returns 8'd17. Required: one set_en pulse carrying exactly those operands; res_valid with candidate=17, tag=0, err=0.
REQ-037 Queue full: hold set_busy=1 and offer 5 jobs back-to-back. Required: job_ready=0 after the 4th acceptance. After set_busy drops and the first ISSUE pops an entry, job_ready returns to 1 one cycle later and the 5th job is accepted with tag=4.
REQ-038 Backpressure: res_ready=0 with 2 jobs queued. Required: after the first result, set_en stays 0 indefinitely. Raising res_ready for one cycle clears res_valid, then the second job issues 1 cycle later.
REQ-039 Timeout: TIMEOUT=16 and the SET model never asserts valid. Required: res_valid with err=1 and candidate=0 exactly 16 cycles after entering WAIT; the next queued job then issues normally.
REQ-040 Tag wrap: 65 jobs with res_ready tied 1. Required: tags 0..63, then 0, in issue order, with no result lost or duplicated.
REQ-041 Reset mid-WAIT: pulse rst for 1 cycle, then the SET model asserts set_valid with candidate=8'd9. Required: every output equals its REQ-034 value, res_valid stays 0, and idle=1.
